// File: rtl/fpmul_pkg.sv
// Shared types and constants for the shared FP multiplier arbiter.
//   fpmul_state_t : arbiter FSM states (IDLE -> CALC -> RESP)
//   FP_QNAN       : canonical quiet NaN returned for Inf/NaN operands
//   FP_EXP_MAX    : exponent field value of Inf/NaN
//   FP_EXP_ZERO   : exponent field value of zero/denormal
//   fp_exp()      : extracts the biased exponent field of a single-precision word
package fpmul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } fpmul_state_t;

  localparam logic [31:0] FP_QNAN     = 32'h7FC00000;
  localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;
  localparam logic [7:0]  FP_EXP_ZERO = 8'h00;

  function automatic logic [7:0] fp_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

endpackage

// File: rtl/multiplierunit.sv
// Combinational IEEE-754 single-precision multiplier core for normal operands.
//   a, b : operands (assumed normal; special cases are handled by the caller)
//   p    : product; mantissa truncated, exponent wraps modulo 256 (no saturation)
module multiplierunit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] p
);

  logic [47:0] prod;
  logic [24:0] prod_top;
  logic [22:0] frac;
  logic [7:0]  exp_sum;

  assign prod     = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
  // Keep only the bits that can reach the result: the normalisation bit plus
  // the 24 bits below it.
  assign prod_top = 25'(prod >> 23);

  // Product of two [1,2) significands lies in [1,4); bit 24 set means it is
  // >= 2, so shift down one place and bump the exponent.
  assign frac     = prod_top[24] ? prod_top[23:1] : prod_top[22:0];
  assign exp_sum  = a[30:23] + b[30:23] - 8'd127 + {7'b0, prod_top[24]};

  assign p = {a[31] ^ b[31], exp_sum, frac};

endmodule

// File: rtl/fpmul_arbiter.sv
// Round-robin arbiter sharing one single-precision multiplier between N_REQ
// requesters, with registered operands/results and zero/Inf/NaN override.
//   clk, reset_n         : clock (rising edge), async active-low reset
//   req_valid/req_ready  : per-requester operand handshake (ready one-hot or zero)
//   req_a, req_b         : per-requester operands
//   rsp_valid/rsp_ready  : result handshake
//   rsp_data/rsp_id      : product and issuing requester index
//   rsp_flags            : [0] zero-override, [1] NaN-override
//   busy                 : high whenever an operation is in flight
//   op_count             : completed response handshakes, wrapping
module fpmul_arbiter
  import fpmul_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ),
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0][31:0] req_a,
  input  logic [N_REQ-1:0][31:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic [1:0]             rsp_flags,
  output logic                   busy,
  output logic [CNT_W-1:0]       op_count
);

  // Returns {found, index} of the first valid requester at or after ptr,
  // wrapping modulo N_REQ. Walks offsets high-to-low so the smallest offset
  // is the last (and therefore final) assignment.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                            input logic [ID_W-1:0]  ptr);
    logic [ID_W:0] res;
    int            idx;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (valid[idx]) res = {1'b1, ID_W'(idx)};
    end
    return res;
  endfunction

  fpmul_state_t    state_reg, state_next;
  logic [ID_W-1:0] rr_ptr_reg;
  logic [31:0]     a_reg, b_reg;
  logic [ID_W-1:0] id_reg;
  logic [31:0]     rsp_data_reg;
  logic [ID_W-1:0] rsp_id_reg;
  logic [1:0]      rsp_flags_reg;
  logic [CNT_W-1:0] op_count_reg;

  logic [ID_W:0]   pick;
  logic            grant_any;
  logic [ID_W-1:0] grant_id;
  logic            grant_fire;
  logic            ready_en;
  logic [31:0]     mul_p;
  logic [31:0]     res_data;
  logic [1:0]      res_flags;

  assign pick       = rr_pick(req_valid, rr_ptr_reg);
  assign grant_any  = pick[ID_W];
  assign grant_id   = pick[ID_W-1:0];
  assign grant_fire = (state_reg == IDLE) && grant_any;

  multiplierunit u_mul (
    .a (a_reg),
    .b (b_reg),
    .p (mul_p)
  );

  // Special operands override the raw unit output; Inf/NaN beats zero.
  always_comb begin
    res_data  = mul_p;
    res_flags = 2'b00;
    if (fp_exp(a_reg) == FP_EXP_MAX || fp_exp(b_reg) == FP_EXP_MAX) begin
      res_data  = FP_QNAN;
      res_flags = 2'b10;
    end else if (fp_exp(a_reg) == FP_EXP_ZERO || fp_exp(b_reg) == FP_EXP_ZERO) begin
      res_data  = {a_reg[31] ^ b_reg[31], 31'b0};
      res_flags = 2'b01;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_any) state_next = CALC;
      CALC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic. Grants are suppressed while reset is held so the ready
  // lines read zero as soon as reset asserts.
  always_comb begin
    rsp_valid = (state_reg == RESP);
    busy      = (state_reg != IDLE);
    ready_en  = (state_reg == IDLE) && reset_n;
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = ready_en && grant_any && (grant_id == ID_W'(gi));
    end
  endgenerate

  // Operand capture, result registration and completion counting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_reg    <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      id_reg        <= '0;
      rsp_data_reg  <= '0;
      rsp_id_reg    <= '0;
      rsp_flags_reg <= '0;
      op_count_reg  <= '0;
    end else begin
      if (grant_fire) begin
        a_reg      <= req_a[grant_id];
        b_reg      <= req_b[grant_id];
        id_reg     <= grant_id;
        rr_ptr_reg <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      end
      if (state_reg == CALC) begin
        rsp_data_reg  <= res_data;
        rsp_flags_reg <= res_flags;
        rsp_id_reg    <= id_reg;
      end
      if (state_reg == RESP && rsp_ready) begin
        op_count_reg <= op_count_reg + CNT_W'(1);
      end
    end
  end

  assign rsp_data  = rsp_data_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_flags = rsp_flags_reg;
  assign op_count  = op_count_reg;

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Self-checking bench for fpmul_arbiter: a queue-based scoreboard fed from a
// transaction-level model (round-robin pick, real-arithmetic product with
// truncation) and a monitor comparing every cycle on the falling edge.
module tb_fpmul_arbiter;

  localparam int N = 4;

  logic             clk;
  logic             reset_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N-1:0][31:0] req_a;
  logic [N-1:0][31:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [1:0]       rsp_id;
  logic [1:0]       rsp_flags;
  logic             busy;
  logic [15:0]      op_count;

  fpmul_arbiter #(.N_REQ(N), .ID_W(2), .CNT_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_flags (rsp_flags),
    .busy      (busy),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  id;
    logic [1:0]  flags;
    int          gcyc;
  } exp_t;

  // Scoreboard and model state
  exp_t        exp_q[$];
  logic [1:0]  rsp_ids[$];
  int          ptr_m;
  bit          in_flight;
  int          count_m;
  int          cyc;
  logic [N-1:0] grant_mask;
  logic [31:0] last_data;
  logic [1:0]  last_id;
  logic [1:0]  last_flags;

  // Stimulus state
  logic [31:0] qa [N][$];
  logic [31:0] qb [N][$];
  bit          eager;
  bit          drop_en;
  bit          ready_rand;
  bit          hold_ready;

  int n_checks;
  int n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, req, $time);
    else n_pass++;
  endtask

  // First valid requester at or after p, modulo N; -1 if none.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Reference product: exact double-precision multiply of the two operands,
  // then truncated back to single precision with an 8-bit wrapping exponent.
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] d, output logic [1:0] f);
    logic [63:0] da, db, dp;
    logic [10:0] de;
    real         prod;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      d = 32'h7FC00000;
      f = 2'b10;
    end else if (a[30:23] == 8'h00 || b[30:23] == 8'h00) begin
      d = {a[31] ^ b[31], 31'b0};
      f = 2'b01;
    end else begin
      da   = {1'b0, 11'(a[30:23]) + 11'd896, a[22:0], 29'b0};
      db   = {1'b0, 11'(b[30:23]) + 11'd896, b[22:0], 29'b0};
      prod = $bitstoreal(da) * $bitstoreal(db);
      dp   = $realtobits(prod);
      de   = dp[62:52] - 11'd896;
      d    = {a[31] ^ b[31], de[7:0], dp[51:29]};
      f    = 2'b00;
    end
  endfunction

  function automatic logic [31:0] rand_op();
    int          k;
    logic [7:0]  e;
    k = $urandom_range(7);
    if (k == 0)      e = 8'hFF;
    else if (k == 1) e = 8'h00;
    else             e = 8'($urandom_range(254, 1));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // Monitor / scoreboard: compares on every falling edge
  initial begin
    logic [N-1:0] exp_ready;
    logic [31:0]  d;
    logic [1:0]   f;
    bit           exp_valid;
    int           w;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        exp_q.delete();
        ptr_m      = 0;
        in_flight  = 0;
        count_m    = 0;
        grant_mask = '0;
      end else begin
        exp_ready = '0;
        w = -1;
        if (!in_flight) begin
          w = pick(req_valid, ptr_m);
          if (w >= 0) exp_ready[w] = 1'b1;
        end
        exp_valid = in_flight && exp_q.size() > 0 && (cyc >= exp_q[0].gcyc + 2);
        chk("busy", 32'(busy), 32'(in_flight));
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("op_count", 32'(op_count), 32'(count_m[15:0]));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        if (rsp_valid && exp_q.size() > 0) begin
          chk("rsp_data", rsp_data, exp_q[0].data);
          chk("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
          chk("rsp_flags", 32'(rsp_flags), 32'(exp_q[0].flags));
        end
        if (rsp_valid && rsp_ready && in_flight) begin
          $display("rsp id=%0d data=%08h flags=%b count=%0d", rsp_id, rsp_data, rsp_flags, count_m + 1);
          last_data  = rsp_data;
          last_id    = rsp_id;
          last_flags = rsp_flags;
          rsp_ids.push_back(rsp_id);
          void'(exp_q.pop_front());
          count_m++;
          in_flight = 0;
        end
        grant_mask = req_ready & req_valid;
        if (w >= 0) begin
          ref_mul(req_a[w], req_b[w], d, f);
          exp_q.push_back('{d, 2'(w), f, cyc});
          in_flight = 1;
          ptr_m     = (w + 1) % N;
        end
      end
    end
  end

  // One clock of stimulus, applied just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
    for (int r = 0; r < N; r++) begin
      if (req_valid[r] && grant_mask[r]) req_valid[r] = 1'b0;
      if (!req_valid[r] && qa[r].size() > 0 && (eager || $urandom_range(3) == 0)) begin
        req_a[r]     = qa[r].pop_front();
        req_b[r]     = qb[r].pop_front();
        req_valid[r] = 1'b1;
      end else if (req_valid[r] && !grant_mask[r] && drop_en && $urandom_range(15) == 0) begin
        req_valid[r] = 1'b0;
      end
    end
    if (hold_ready)      rsp_ready = 1'b0;
    else if (ready_rand) rsp_ready = ($urandom_range(3) != 0);
    else                 rsp_ready = 1'b1;
  endtask

  function automatic bit queues_empty();
    for (int r = 0; r < N; r++) if (qa[r].size() > 0) return 0;
    return 1;
  endfunction

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(queues_empty() && req_valid == '0 && !in_flight && exp_q.size() == 0) && n < budget);
    if (n >= budget) begin
      n_checks++;
      $display("FAIL timeout: no idle after %0d cycles, expected idle", budget);
    end
  endtask

  task automatic push(input int r, input logic [31:0] a, input logic [31:0] b);
    qa[r].push_back(a);
    qb[r].push_back(b);
  endtask

  task automatic dir(input string name, input int r, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] d, input logic [1:0] f);
    push(r, a, b);
    run_until_idle(50);
    chk({name, "_data"}, last_data, d);
    chk({name, "_id"}, 32'(last_id), 32'(r));
    chk({name, "_flags"}, 32'(last_flags), 32'(f));
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({name, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({name, "_rsp_data"}, rsp_data, 32'd0);
    chk({name, "_rsp_id"}, 32'(rsp_id), 32'd0);
    chk({name, "_rsp_flags"}, 32'(rsp_flags), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_op_count"}, 32'(op_count), 32'd0);
  endtask

  initial begin
    int n;
    n_checks   = 0;
    n_pass     = 0;
    reset_n    = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 1'b0;
    eager      = 1'b1;
    drop_en    = 1'b0;
    ready_rand = 1'b0;
    hold_ready = 1'b0;

    // Reset state, with every requester asking so grants must be masked
    repeat (2) @(posedge clk);
    req_valid = '1;
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    req_valid = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // T1..T3: directed products and overrides
    dir("t1_2x3", 0, 32'h40000000, 32'h40400000, 32'h40C00000, 2'b00);
    dir("t2_1p5sq", 1, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 2'b00);
    dir("t2_neg", 2, 32'hC0000000, 32'h40400000, 32'hC0C00000, 2'b00);
    dir("t3_inf", 0, 32'h7F800000, 32'h3F800000, 32'h7FC00000, 2'b10);
    dir("t3_zero", 3, 32'h00000000, 32'hC0400000, 32'h80000000, 2'b01);

    // T4: all four requesters continuously valid for 8 ops
    rsp_ids.delete();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < N; r++) push(r, rand_op(), rand_op());
    run_until_idle(100);
    chk("t4_n_rsp", 32'(rsp_ids.size()), 32'd8);
    for (int k = 0; k < rsp_ids.size() && k < 8; k++)
      chk($sformatf("t4_order%0d", k), 32'(rsp_ids[k]), 32'(k % N));
    chk("t4_op_count", 32'(op_count), 32'd13);

    // T5: consumer stalls for 10 cycles while the response waits
    hold_ready = 1'b1;
    push(1, 32'h3F800000, 32'h40490FDB);
    n = 0;
    do begin
      step();
      n++;
    end while (!rsp_valid && n < 20);
    chk("t5_rsp_valid_seen", 32'(rsp_valid), 32'd1);
    repeat (10) step();
    chk("t5_still_pending", 32'(op_count), 32'd13);
    hold_ready = 1'b0;
    run_until_idle(20);
    chk("t5_data", last_data, 32'h40490FDB);
    chk("t5_op_count", 32'(op_count), 32'd14);

    // T6: reset during CALC discards the op
    push(2, 32'h40000000, 32'h40000000);
    n = 0;
    do begin
      step();
      n++;
    end while (!(busy && !rsp_valid) && n < 20);
    chk("t6_in_calc", 32'(busy && !rsp_valid), 32'd1);
    #2;
    reset_n   = 1'b0;
    req_valid = '0;
    for (int r = 0; r < N; r++) begin
      qa[r].delete();
      qb[r].delete();
    end
    #1;
    check_reset_outputs("t6");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) step();
    rsp_ids.delete();
    push(2, 32'h40000000, 32'h40800000);
    push(0, 32'h40400000, 32'h40400000);
    run_until_idle(50);
    chk("t6_n_rsp", 32'(rsp_ids.size()), 32'd2);
    if (rsp_ids.size() >= 2) begin
      chk("t6_first", 32'(rsp_ids[0]), 32'd0);
      chk("t6_second", 32'(rsp_ids[1]), 32'd2);
    end

    // Randomised traffic: random arrivals, withdrawals and back-pressure
    eager      = 1'b0;
    drop_en    = 1'b1;
    ready_rand = 1'b1;
    for (int k = 0; k < 60; k++) push($urandom_range(N - 1), rand_op(), rand_op());
    run_until_idle(5000);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
